// File: rtl/dbram_port_arbiter.sv
// Two-port arbiter in front of the single-port data scratchpad BRAM.
// LS has fixed priority; a starvation counter forces a DMA grant; reads return through per-port skid registers.
module dbram_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_req,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W/8-1:0]   ls_we,
  input  logic [DATA_W-1:0]     ls_wdata,
  output logic                  ls_gnt,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  ls_rvalid,
  input  logic                  ls_rack,
  input  logic                  dma_req,
  input  logic [ADDR_W-1:0]     dma_addr,
  input  logic [DATA_W/8-1:0]   dma_we,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  dma_rvalid,
  input  logic                  dma_rack,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W/8-1:0]   bram_be,
  output logic [DATA_W-1:0]     bram_wdata,
  input  logic [DATA_W-1:0]     bram_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int NP   = 2;  // port 0 = LS, port 1 = DMA

  logic [NP-1:0]             req, rack, gnt, pend, hold, elig, rvalid;
  logic [NP-1:0][BE_W-1:0]   we;
  logic [NP-1:0][DATA_W-1:0] hold_data, rdata;
  logic [3:0]                wait_cnt;
  logic                      rst_q, arb_ok;

  assign req  = {dma_req, ls_req};
  assign rack = {dma_rack, ls_rack};
  assign we   = {dma_we, ls_we};

  // Grants stay off in the reset cycle and the one after it.
  assign arb_ok = ~rst & ~rst_q;

  always_comb begin
    elig   = '0;
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < NP; i++) begin
      elig[i]   = req[i] & ~((pend[i] | hold[i]) & ~rack[i]) & arb_ok;
      rvalid[i] = (pend[i] | hold[i]) & ~rst;
      if (rvalid[i])
        rdata[i] = hold[i] ? hold_data[i] : bram_rdata;
    end
  end

  assign dma_gnt = elig[1] & (~elig[0] | (wait_cnt == 4'(MAX_WAIT)));
  assign ls_gnt  = elig[0] & ~dma_gnt;
  assign gnt     = {dma_gnt, ls_gnt};

  assign ls_rvalid  = rvalid[0];
  assign ls_rdata   = rdata[0];
  assign dma_rvalid = rvalid[1];
  assign dma_rdata  = rdata[1];

  always_comb begin
    bram_en    = ls_gnt | dma_gnt;
    bram_addr  = '0;
    bram_be    = '0;
    bram_wdata = '0;
    if (ls_gnt) begin
      bram_addr  = ls_addr;
      bram_be    = ls_we;
      bram_wdata = ls_wdata;
    end else if (dma_gnt) begin
      bram_addr  = dma_addr;
      bram_be    = dma_we;
      bram_wdata = dma_wdata;
    end
  end

  // pend: read issued last cycle, data on bram_rdata now. hold: data parked in skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      hold  <= '0;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        pend[i] <= gnt[i] & ~|we[i];
        hold[i] <= (pend[i] | hold[i]) & ~rack[i];
      end
    end
    for (int i = 0; i < NP; i++)
      if (pend[i] & ~rack[i])
        hold_data[i] <= bram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst || !dma_req || dma_gnt)
      wait_cnt <= '0;
    else if (wait_cnt != 4'(MAX_WAIT))
      wait_cnt <= wait_cnt + 4'd1;
  end
endmodule

// File: tb/tb_dbram_port_arbiter.sv
// Bench for dbram_port_arbiter: BRAM model, queue-based reference of the arbitration rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dbram_port_arbiter;
  localparam int AW = 12, DW = 32, BW = 4, MW = 4;

  logic clk = 1'b0;
  logic rst;
  logic ls_req, ls_rack, dma_req, dma_rack;
  logic [AW-1:0] ls_addr, dma_addr;
  logic [BW-1:0] ls_we, dma_we;
  logic [DW-1:0] ls_wdata, dma_wdata;
  logic ls_gnt, ls_rvalid, dma_gnt, dma_rvalid, bram_en;
  logic [DW-1:0] ls_rdata, dma_rdata, bram_wdata, bram_rdata;
  logic [AW-1:0] bram_addr;
  logic [BW-1:0] bram_be;

  always #5 clk = ~clk;

  dbram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid), .ls_rack(ls_rack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_rack(dma_rack),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_be(bram_be),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM: 1-cycle read, output is garbage on any cycle without a read response.
  logic [DW-1:0] mem [0:4095];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_en && bram_be != 0)
      for (int b = 0; b < BW; b++)
        if (bram_be[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
    if (bram_en && bram_be == 0) bram_rdata <= mem[bram_addr];
    else                         bram_rdata <= $urandom;
  end

  // Reference model: each port owns a queue of read data still owed to it.
  logic [DW-1:0] lq[$], dq[$];
  int  wcnt = 0;
  bit  rstq_m = 1'b1;
  int  checks = 0, failures = 0;

  logic          s_ls_gnt, s_dma_gnt, s_ls_rvalid, s_dma_rvalid, s_bram_en;
  logic [DW-1:0] s_ls_rdata, s_dma_rdata, s_bram_wdata;
  logic [AW-1:0] s_bram_addr;
  logic [BW-1:0] s_bram_be;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    bit arb_ok, l_el, d_el, e_lg, e_dg, e_lv, e_dv;
    logic [DW-1:0] e_ld, e_dd, e_wd, l_val, d_val;
    logic [AW-1:0] e_ad;
    logic [BW-1:0] e_be;
    @(negedge clk); #1;
    arb_ok = !rst && !rstq_m;
    l_el = ls_req  && !(lq.size() > 0 && !ls_rack)  && arb_ok;
    d_el = dma_req && !(dq.size() > 0 && !dma_rack) && arb_ok;
    e_dg = d_el && (!l_el || wcnt == MW);
    e_lg = l_el && !e_dg;
    e_lv = !rst && lq.size() > 0;
    e_dv = !rst && dq.size() > 0;
    e_ld = e_lv ? lq[0] : '0;
    e_dd = e_dv ? dq[0] : '0;
    e_ad = e_lg ? ls_addr  : e_dg ? dma_addr  : '0;
    e_be = e_lg ? ls_we    : e_dg ? dma_we    : '0;
    e_wd = e_lg ? ls_wdata : e_dg ? dma_wdata : '0;
    l_val = mem[ls_addr];
    d_val = mem[dma_addr];
    s_ls_gnt = ls_gnt; s_dma_gnt = dma_gnt; s_ls_rvalid = ls_rvalid; s_dma_rvalid = dma_rvalid;
    s_ls_rdata = ls_rdata; s_dma_rdata = dma_rdata; s_bram_en = bram_en;
    s_bram_addr = bram_addr; s_bram_be = bram_be; s_bram_wdata = bram_wdata;
    chk("ls_gnt", DW'(ls_gnt), DW'(e_lg));
    chk("dma_gnt", DW'(dma_gnt), DW'(e_dg));
    chk("ls_rvalid", DW'(ls_rvalid), DW'(e_lv));
    chk("dma_rvalid", DW'(dma_rvalid), DW'(e_dv));
    chk("ls_rdata", ls_rdata, e_ld);
    chk("dma_rdata", dma_rdata, e_dd);
    chk("bram_en", DW'(bram_en), DW'(e_lg || e_dg));
    chk("bram_addr", DW'(bram_addr), DW'(e_ad));
    chk("bram_be", DW'(bram_be), DW'(e_be));
    chk("bram_wdata", bram_wdata, e_wd);
    @(posedge clk); #1;
    if (rst) begin
      lq.delete(); dq.delete(); wcnt = 0; rstq_m = 1'b1;
    end else begin
      rstq_m = 1'b0;
      if (e_lv && ls_rack)  void'(lq.pop_front());
      if (e_dv && dma_rack) void'(dq.pop_front());
      if (e_lg && ls_we == 0)  lq.push_back(l_val);
      if (e_dg && dma_we == 0) dq.push_back(d_val);
      wcnt = (dma_req && !e_dg) ? ((wcnt < MW) ? wcnt + 1 : MW) : 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ls_gnt"}, DW'(s_ls_gnt), '0);
    chk({tag, "_dma_gnt"}, DW'(s_dma_gnt), '0);
    chk({tag, "_ls_rvalid"}, DW'(s_ls_rvalid), '0);
    chk({tag, "_dma_rvalid"}, DW'(s_dma_rvalid), '0);
    chk({tag, "_bram_en"}, DW'(s_bram_en), '0);
    chk({tag, "_bram_addr"}, DW'(s_bram_addr), '0);
  endtask

  task automatic new_req(output logic req, output logic [AW-1:0] a,
                         output logic [BW-1:0] w, output logic [DW-1:0] d);
    req = ($urandom_range(0, 3) != 0);
    a   = AW'($urandom_range(0, 63));
    w   = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
    d   = $urandom;
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    ls_req = 0; ls_addr = '0; ls_we = '0; ls_wdata = '0; ls_rack = 0;
    dma_req = 0; dma_addr = '0; dma_we = '0; dma_wdata = '0; dma_rack = 0;

    // Preload under reset; the reset cycles check the quiet outputs.
    pl_en = 1'b1;
    for (int i = 0; i < 66; i++) begin
      pl_addr = (i == 64) ? AW'(12'h010) : (i == 65) ? AW'(12'h020) : AW'(i);
      pl_data = (i == 64) ? 32'hDEADBEEF : (i == 65) ? 32'h00000055 : $urandom;
      step();
    end
    chk_zero("rst");
    pl_en = 1'b0; rst = 1'b0;
    step(); chk_zero("post_rst");

    // Single LS read with immediate ack.
    ls_req = 1; ls_addr = 12'h010; ls_we = '0;
    step(); chk("t1_gnt", DW'(s_ls_gnt), 1); chk("t1_addr", DW'(s_bram_addr), 32'h010);
    ls_req = 0; ls_rack = 1;
    step(); chk("t1_rvalid", DW'(s_ls_rvalid), 1); chk("t1_rdata", s_ls_rdata, 32'hDEADBEEF);
    ls_rack = 0;
    step(); chk("t1_rvalid_off", DW'(s_ls_rvalid), 0);

    // Delayed ack: data parked while bram_rdata wanders; next request waits for the ack.
    ls_req = 1; ls_addr = 12'h010;
    step();
    ls_addr = 12'h011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_gnt_blk", DW'(s_ls_gnt), 0);
      chk("t2_rvalid", DW'(s_ls_rvalid), 1);
      chk("t2_rdata", s_ls_rdata, 32'hDEADBEEF);
    end
    ls_rack = 1;
    step(); chk("t2_gnt_ack", DW'(s_ls_gnt), 1); chk("t2_rdata_ack", s_ls_rdata, 32'hDEADBEEF);
    ls_req = 0;
    step(); chk("t2_rvalid2", DW'(s_ls_rvalid), 1);
    ls_rack = 0;
    step();

    // Continuous contention: four LS grants, then DMA.
    ls_req = 1; ls_addr = 12'd40; ls_we = 4'hF; ls_wdata = 32'h11111111;
    dma_req = 1; dma_addr = 12'd41; dma_we = 4'hF; dma_wdata = 32'h22222222;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t3_dma_gnt", DW'(s_dma_gnt), DW'(i == 4));
      chk("t3_ls_gnt", DW'(s_ls_gnt), DW'(i != 4));
    end

    // Starved DMA write beats a same-cycle LS read.
    dma_addr = 12'h3FF; dma_we = 4'b0011; dma_wdata = 32'hAABBCCDD;
    ls_addr = 12'h010; ls_we = '0;
    step();
    chk("t4_dma_gnt", DW'(s_dma_gnt), 1); chk("t4_ls_gnt", DW'(s_ls_gnt), 0);
    chk("t4_be", DW'(s_bram_be), 32'h3); chk("t4_addr", DW'(s_bram_addr), 32'h3FF);
    chk("t4_wdata", s_bram_wdata, 32'hAABBCCDD);
    dma_req = 0;
    step(); chk("t4_ls_late", DW'(s_ls_gnt), 1); chk("t4_no_drv", DW'(s_dma_rvalid), 0);
    ls_req = 0; ls_rack = 1;
    step(); chk("t4_ls_rdata", s_ls_rdata, 32'hDEADBEEF); chk("t4_no_drv2", DW'(s_dma_rvalid), 0);

    // DMA read independent of an unacked LS read.
    ls_rack = 0; ls_req = 1; ls_addr = 12'h010;
    step();
    ls_req = 0; dma_req = 1; dma_addr = 12'h020; dma_we = '0;
    step(); chk("t5_dma_gnt", DW'(s_dma_gnt), 1); chk("t5_ls_rv", DW'(s_ls_rvalid), 1);
    dma_req = 0; dma_rack = 1;
    step();
    chk("t5_dma_rv", DW'(s_dma_rvalid), 1); chk("t5_dma_rdata", s_dma_rdata, 32'h55);
    chk("t5_ls_rdata", s_ls_rdata, 32'hDEADBEEF);
    dma_rack = 0; ls_rack = 1;
    step();
    ls_rack = 0;

    // Reset right after a DMA read grant drops the read.
    dma_req = 1; dma_addr = 12'h020;
    step(); chk("t6_dma_gnt", DW'(s_dma_gnt), 1);
    rst = 1; ls_req = 1; ls_addr = 12'h010;
    step(); chk_zero("t6_rst");
    rst = 0;
    step(); chk_zero("t6_post");
    step(); chk("t6_dma_rv", DW'(s_dma_rvalid), 0); chk("t6_ls_gnt", DW'(s_ls_gnt), 1);
    ls_req = 0; dma_req = 0; ls_rack = 1; dma_rack = 1;
    step(); step();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!ls_req || s_ls_gnt)   new_req(ls_req, ls_addr, ls_we, ls_wdata);
      if (!dma_req || s_dma_gnt) new_req(dma_req, dma_addr, dma_we, dma_wdata);
      ls_rack  = ($urandom_range(0, 9) < 7);
      dma_rack = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbram_port_arbiter.md
Name: dbram_port_arbiter

Overview:
Shares the single-port data scratchpad BRAM between two requesters: the load/store unit's BRAM sub-unit port and an accelerator/UART DMA port. Each cycle it grants at most one request. The load/store unit has fixed priority, and a starvation counter guarantees the DMA port a grant. Read data from the 1-cycle-latency BRAM is routed back to its owner through a per-requester skid register, so a requester may delay its acknowledgement without losing data.

Parameters:
ADDR_W, 12, BRAM word-address width
DATA_W, 32, data width; byte enables are DATA_W/8 wide
MAX_WAIT, 4, consecutive lost arbitration cycles after which DMA wins (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ls_req  in  1  LS request; held until granted
ls_addr  in  ADDR_W  LS word address
ls_we  in  DATA_W/8  LS byte write enables; all zero = read
ls_wdata  in  DATA_W  LS store data
ls_gnt  out  1  LS request accepted this cycle
ls_rdata  out  DATA_W  LS read data
ls_rvalid  out  1  LS read data valid
ls_rack  in  1  LS consumes read data
dma_req, dma_addr, dma_we, dma_wdata, dma_gnt, dma_rdata, dma_rvalid, dma_rack  same as ls_*, DMA requester
bram_en  out  1  BRAM access enable
bram_addr  out  ADDR_W  BRAM address
bram_be  out  DATA_W/8  BRAM byte write enables
bram_wdata  out  DATA_W  BRAM write data
bram_rdata  in  DATA_W  BRAM read data, valid the cycle after bram_en with bram_be==0

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset: all pending flags, hold flags and the wait counter clear. All *_gnt, *_rvalid and bram_en read 0 in the reset cycle and the cycle after it. Any read in flight when reset is applied is dropped; its rvalid never asserts.
- Requester blocking: a requester X is blocked when pend_X is set (read issued last cycle) or hold_X is set (data parked), unless X asserts X_rack that cycle.
- Eligibility: X is eligible when X_req=1 and X is not blocked.
- Grant selection (combinational):
  - dma_gnt = dma eligible AND (ls not eligible OR wait_cnt == MAX_WAIT).
  - ls_gnt = ls eligible AND NOT dma_gnt.
  - At most one grant per cycle.
- BRAM drive: bram_en = ls_gnt | dma_gnt. Address, be and wdata are muxed from the granted requester. When idle, outputs are 0.
- Writes: complete on grant and produce no response. Throughput is 1 per cycle.
- Read latency: a read granted in cycle N sets pend_X for cycle N+1. In N+1, X_rvalid=1 and X_rdata = bram_rdata (bypass path).
  - If X_rack=0 in N+1, bram_rdata is captured into hold_X.
  - X_rvalid then stays 1 with X_rdata = hold data until X_rack.
  - rvalid and rdata must be stable while unacknowledged.
- Back-to-back reads: X_rack in the rvalid cycle permits a new grant to X in that same cycle. Same-requester reads therefore sustain 1 per cycle.
- Independence: one requester's outstanding read never blocks the other requester's grants or responses.
- Starvation counter wait_cnt (4 bits):
  - Increments when dma_req=1 and dma_gnt=0, saturating at MAX_WAIT.
  - Clears on dma_gnt, and when dma_req=0.
- Simultaneous events:
  - Both requesters eligible and wait_cnt < MAX_WAIT: LS wins.
  - Pend and hold for the same requester never coexist, because the grant requires ~pend | rack.
  - A requester asserting rack without rvalid has no effect.
- Illegal input: X_req may not change address or data while waiting for a grant; behaviour in that case is undefined.

Test Plan:
- Reset, then LS read of addr 0x010 with BRAM word 0xDEADBEEF: ls_gnt in cycle 1, ls_rvalid=1 and ls_rdata=0xDEADBEEF in cycle 2; with ls_rack=1 in cycle 2, ls_rvalid=0 in cycle 3.
- LS read with ls_rack held 0 for 5 cycles while BRAM rdata changes to 0x12345678: ls_rdata stays 0xDEADBEEF and ls_rvalid stays 1 until the rack cycle. A new ls_req is not granted until that cycle.
- LS and DMA both request continuously with MAX_WAIT=4: LS is granted 4 cycles, DMA on the 5th, and the pattern repeats. No cycle asserts both grants.
- DMA write addr 0x3FF, we=4'b0011, wdata 0xAABBCCDD: bram_en=1, bram_be=0011, bram_addr=0x3FF in the grant cycle; no dma_rvalid follows. A same-cycle LS read is granted the next cycle.
- LS read outstanding (rvalid, no rack) while DMA reads 0x020 (=0x55): DMA is granted immediately and dma_rdata=0x55 returns one cycle later, independent of LS.
- Assert rst in the cycle after a DMA read grant: dma_rvalid never asserts, and all outputs are 0 for 2 cycles.
